// File: rtl/axioma_eeprom_array.sv
// Timed byte-array backend for the EEPROM controller: one command in flight,
// with read/erase/program phase latencies enforced by a single down-counter.
module axioma_eeprom_array #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned READ_CYCLES  = 4,
    parameter int unsigned ERASE_CYCLES = 3400,
    parameter int unsigned PROG_CYCLES  = 3400
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              done,
    output logic              busy,
    output logic [2:0]        debug_state,
    output logic [15:0]       debug_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] OP_ERASE_WRITE = 2'b00;
    localparam logic [1:0] OP_ERASE       = 2'b01;
    localparam logic [1:0] OP_WRITE       = 2'b10;
    localparam logic [1:0] OP_READ        = 2'b11;

    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PROG_LOAD  = CNT_W'(PROG_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_ERASE = 3'd2,
        ST_PROG  = 3'd3
    } state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
    } cmd_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    cmd_t             cmd_q;
    logic             done_q;
    logic             done_nxt;
    logic             rsp_valid_q;
    logic             rsp_valid_nxt;
    logic [7:0]       rsp_rdata_q;
    logic [7:0]       rsp_rdata_nxt;
    logic             accept_c;
    logic             phase_end_c;
    logic [7:0]       cur_byte_c;
    logic             mem_we_c;
    logic [7:0]       mem_wdata_c;

    // Cells are held inverted so the zero-initialised array reads as erased (0xFF).
    logic [7:0] mem_n [DEPTH];

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = ~cmd_ready;
    assign accept_c    = cmd_valid && cmd_ready;
    assign phase_end_c = (count_q == '0);
    assign cur_byte_c  = ~mem_n[cmd_q.addr];

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign done        = done_q;
    assign debug_state = state_q;
    assign debug_count = count_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_READ:  state_nxt = ST_READ;
                        OP_WRITE: state_nxt = ST_PROG;
                        default:  state_nxt = ST_ERASE;
                    endcase
                end
            end
            ST_READ:  if (phase_end_c) state_nxt = ST_IDLE;
            ST_ERASE: if (phase_end_c) state_nxt = (cmd_q.op == OP_ERASE_WRITE) ? ST_PROG : ST_IDLE;
            ST_PROG:  if (phase_end_c) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Counter, response and array-write decode
    always_comb begin
        count_nxt     = count_q;
        done_nxt      = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata_q;
        mem_we_c      = 1'b0;
        mem_wdata_c   = 8'hFF;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_READ:  count_nxt = READ_LOAD;
                        OP_WRITE: count_nxt = PROG_LOAD;
                        default:  count_nxt = ERASE_LOAD;
                    endcase
                end
            end
            ST_READ: begin
                if (phase_end_c) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = cur_byte_c;
                    done_nxt      = 1'b1;
                end else begin
                    count_nxt = count_q - CNT_W'(1);
                end
            end
            ST_ERASE: begin
                // Erase+write commits only at program end, so an abort leaves the byte intact.
                if (phase_end_c) begin
                    if (cmd_q.op == OP_ERASE_WRITE) begin
                        count_nxt = PROG_LOAD;
                    end else begin
                        mem_we_c = 1'b1;
                        done_nxt = 1'b1;
                    end
                end else begin
                    count_nxt = count_q - CNT_W'(1);
                end
            end
            ST_PROG: begin
                if (phase_end_c) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = (cmd_q.op == OP_ERASE_WRITE) ? cmd_q.wdata
                                                               : (cur_byte_c & cmd_q.wdata);
                    done_nxt    = 1'b1;
                end else begin
                    count_nxt = count_q - CNT_W'(1);
                end
            end
            default: count_nxt = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            cmd_q       <= '0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            count_q     <= count_nxt;
            done_q      <= done_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
            if (accept_c) begin
                cmd_q <= '{op: cmd_op, addr: cmd_addr, wdata: cmd_wdata};
            end
        end
    end

    // Array write port; not reset so contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_n[cmd_q.addr] <= ~mem_wdata_c;
        end
    end

endmodule

// File: tb/tb_axioma_eeprom_array.sv
// Directed bench for axioma_eeprom_array: per-cycle compare against a
// transaction-level model plus hand-computed latency and data checks.
module tb_axioma_eeprom_array;

    localparam int RD_C = 4;
    localparam int ER_C = 8;
    localparam int PR_C = 6;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [9:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       done;
    logic       busy;
    logic [2:0] debug_state;
    logic [15:0] debug_count;

    axioma_eeprom_array #(
        .ADDR_W      (10),
        .READ_CYCLES (RD_C),
        .ERASE_CYCLES(ER_C),
        .PROG_CYCLES (PR_C)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .done       (done),
        .busy       (busy),
        .debug_state(debug_state),
        .debug_count(debug_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_pass;
    bit chk_en;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Transaction-level model: command accepted when idle, effects land L edges later
    int       edge_n;
    bit       m_busy;
    int       m_end;
    bit [1:0] m_op;
    bit [9:0] m_addr;
    bit [7:0] m_wdata;
    bit       m_done;
    bit       m_rsp;
    bit [7:0] m_rdata;
    bit       m_written [1024];
    bit [7:0] m_val     [1024];

    function automatic int lat_of(input bit [1:0] op);
        case (op)
            2'b00:   return ER_C + PR_C;
            2'b01:   return ER_C;
            2'b10:   return PR_C;
            default: return RD_C;
        endcase
    endfunction

    function automatic bit [7:0] m_rd(input bit [9:0] a);
        return m_written[a] ? m_val[a] : 8'hFF;
    endfunction

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_rsp   <= 1'b0;
            m_rdata <= 8'h00;
        end else begin
            m_done <= 1'b0;
            m_rsp  <= 1'b0;
            if (m_busy) begin
                if (edge_n == m_end) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_written[m_addr] <= 1'b1;
                    case (m_op)
                        2'b00: m_val[m_addr] <= m_wdata;
                        2'b01: m_val[m_addr] <= 8'hFF;
                        2'b10: m_val[m_addr] <= m_rd(m_addr) & m_wdata;
                        default: begin
                            m_val[m_addr] <= m_rd(m_addr);
                            m_rdata       <= m_rd(m_addr);
                            m_rsp         <= 1'b1;
                        end
                    endcase
                end
            end else if (cmd_valid) begin
                m_busy  <= 1'b1;
                m_op    <= cmd_op;
                m_addr  <= cmd_addr;
                m_wdata <= cmd_wdata;
                m_end   <= edge_n + lat_of(cmd_op);
            end
        end
    end

    // Per-cycle comparison of every visible output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", int'(cmd_ready), int'(!m_busy));
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(m_done));
            chk("rsp_valid", int'(rsp_valid), int'(m_rsp));
            chk("rsp_rdata", int'(rsp_rdata), int'(m_rdata));
            if (!m_busy) begin
                chk("idle_state", int'(debug_state), 0);
                chk("idle_count", int'(debug_count), 0);
            end
        end
    end

    int acc_edge;
    int done_edge;

    task automatic issue(input logic [1:0] op, input logic [9:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge clk);
        #1 acc_edge = edge_n;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = ~a;
        cmd_wdata = ~d;
    endtask

    task automatic wait_done(input string nm, input int exp_lat);
        int lat;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                lat = edge_n - acc_edge;
                break;
            end
            @(negedge clk);
        end
        done_edge = edge_n;
        chk(nm, lat, exp_lat);
    endtask

    task automatic do_read(input logic [9:0] a, input logic [7:0] exp_v);
        issue(2'b11, a, 8'h00);
        wait_done("read_latency", RD_C);
        chk("read_rsp_valid", int'(rsp_valid), 1);
        chk("read_data", int'(rsp_rdata), int'(exp_v));
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_wdata = '0;
        reset_n   = 1'b1;
        #3 reset_n = 1'b0;
        #4;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rdata", int'(rsp_rdata), 0);
        chk("rst_state", int'(debug_state), 0);
        chk("rst_count", int'(debug_count), 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Read of an untouched byte
        do_read(10'h155, 8'hFF);

        // Erase+write then read back
        issue(2'b00, 10'h3FF, 8'h3C);
        wait_done("ew_latency", 14);
        do_read(10'h3FF, 8'h3C);

        // Write-only ANDs into existing content, erase-only restores 0xFF
        issue(2'b10, 10'h3FF, 8'hF0);
        wait_done("wr_latency", 6);
        do_read(10'h3FF, 8'h30);
        issue(2'b01, 10'h3FF, 8'h00);
        wait_done("er_latency", 8);
        do_read(10'h3FF, 8'hFF);

        // Requests while busy are dropped; inputs changed after acceptance are ignored
        issue(2'b00, 10'h020, 8'h77);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_addr  = 10'h021;
        cmd_wdata = 8'h00;
        repeat (10) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done("busy_ew_latency", 14);
        do_read(10'h020, 8'h77);
        do_read(10'h021, 8'hFF);

        // Reset during the program phase of erase+write preserves the old byte
        issue(2'b00, 10'h010, 8'hA5);
        wait_done("pre_ew_latency", 14);
        issue(2'b00, 10'h010, 8'h55);
        while (edge_n - acc_edge < 9) begin
            @(posedge clk);
            #1;
        end
        #1 reset_n = 1'b0;
        #1;
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_state", int'(debug_state), 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        do_read(10'h010, 8'hA5);

        // Back-to-back: read accepted on the edge right after the write completes
        issue(2'b10, 10'h3FF, 8'h0F);
        wait_done("b2b_wr_latency", 6);
        issue(2'b11, 10'h3FF, 8'h00);
        chk("b2b_accept_gap", acc_edge - done_edge, 1);
        wait_done("b2b_rd_latency", 4);
        chk("b2b_rdata", int'(rsp_rdata), 8'h0F);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
